// File: rtl/cpu_pkg.sv
// cpu_pkg: shared mdu op encodings and FSM state constants
package cpu_pkg;
    typedef logic [1:0] mdu_state_t;
    localparam mdu_state_t S_IDLE = 2'd0;
    localparam mdu_state_t S_CALC = 2'd1;
    localparam mdu_state_t S_FIX  = 2'd2;
    localparam mdu_state_t S_DONE = 2'd3;
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/response handshake bundle of the multiply/divide unit
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mdu_op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             busy;
    modport master (output flush, in_valid, mdu_op, src1, src2, out_ready,
                    input in_ready, out_valid, res_lo, res_hi, busy);
    modport slave (input flush, in_valid, mdu_op, src1, src2, out_ready,
                   output in_ready, out_valid, res_lo, res_hi, busy);
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: operand magnitudes on accept and result sign correction in FIX
module mdu_sign_fix #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sgn,
    output logic [WIDTH-1:0] mag1,
    output logic [WIDTH-1:0] mag2,
    output logic             s1,
    output logic             s2,
    input  logic             is_div,
    input  logic             n1,
    input  logic             n2,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        s1 = sgn & src1[WIDTH-1];
        s2 = sgn & src2[WIDTH-1];
        mag1 = s1 ? -src1 : src1;
        mag2 = s2 ? -src2 : src2;
        prod = (n1 ^ n2) ? -{hi, lo} : {hi, lo};
        // remainder follows the dividend's sign, quotient the xor of signs
        fix_lo = is_div ? ((n1 ^ n2) ? -lo : lo) : prod[WIDTH-1:0];
        fix_hi = is_div ? (n1 ? -hi : hi) : prod[2*WIDTH-1:WIDTH];
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 signed/unsigned multiplier and restoring divider
module mul_div_unit
    import cpu_pkg::*;
#(parameter int WIDTH = 32) (
    input logic         clk,
    input logic         rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    mdu_state_t       state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b, m, res_lo, res_hi;
    logic [WIDTH-1:0] mag1, mag2, fix_hi, fix_lo;
    logic             n1, n2, s1, s2, is_div, sgn_in, div0_in;
    logic [WIDTH:0]   sum, rsh, diff;
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign sgn_in  = (bus.mdu_op == OP_MUL) || (bus.mdu_op == OP_DIV);
    assign div0_in = bus.mdu_op[1] && (bus.src2 == '0);
    // a holds the product high half / partial remainder, b the multiplier / quotient
    always_comb begin
        sum  = {1'b0, a} + (b[0] ? {1'b0, m} : '0);
        rsh  = {a, b[WIDTH-1]};
        diff = rsh - {1'b0, m};
    end
    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .src1(bus.src1), .src2(bus.src2), .sgn(sgn_in), .mag1(mag1), .mag2(mag2),
        .s1(s1), .s2(s2), .is_div(is_div), .n1(n1), .n2(n2), .hi(a), .lo(b),
        .fix_hi(fix_hi), .fix_lo(fix_lo)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op     <= '0;
            a      <= '0;
            b      <= '0;
            m      <= '0;
            n1     <= 1'b0;
            n2     <= 1'b0;
            res_lo <= '0;
            res_hi <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    state <= S_CALC;
                    cnt   <= '0;
                    op    <= bus.mdu_op;
                    a     <= '0;
                    b     <= div0_in ? bus.src1 : mag1;
                    m     <= mag2;
                    n1    <= s1;
                    n2    <= s2;
                end
                S_CALC: if (is_div && m == '0) begin
                    state  <= S_DONE;
                    res_lo <= '1;
                    res_hi <= b;
                end else begin
                    a   <= is_div ? (diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
                    b   <= is_div ? {b[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], b[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    res_lo <= fix_lo;
                    res_hi <= fix_hi;
                    state  <= S_DONE;
                end
                default: if (bus.out_ready) state <= S_IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state == S_IDLE;
    assign bus.busy      = state != S_IDLE;
    assign bus.out_valid = state == S_DONE;
    assign bus.res_lo    = res_lo;
    assign bus.res_hi    = res_hi;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed results
module tb_mul_div_unit;
    import cpu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int lat;
    logic seen;
    logic [31:0] hold_lo, hold_hi;
    mul_div_unit_if #(.WIDTH(32)) bus ();
    mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // present one request, then count edges after the accept edge until out_valid
    task automatic run(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2, output int n);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mdu_op = op;
        bus.src1 = s1;
        bus.src2 = s2;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic handshake();
        @(posedge clk);
        #1 chk("hs_ready", {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.mdu_op = 2'b00;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_ovalid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_lo", {32'd0, bus.res_lo}, 64'd0);
        chk("rst_hi", {32'd0, bus.res_hi}, 64'd0);
        rst = 1'b0;
        chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);

        run(OP_MUL, 32'hFFFFFFFF, 32'h00000002, lat);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_res", {bus.res_hi, bus.res_lo}, 64'hFFFFFFFF_FFFFFFFE);
        chk("mul_busy", {63'd0, bus.busy}, 64'd1);
        handshake();

        run(OP_MULU, 32'hFFFFFFFF, 32'h00000002, lat);
        chk("mulu_res", {bus.res_hi, bus.res_lo}, 64'h00000001_FFFFFFFE);
        handshake();

        run(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_res", {bus.res_hi, bus.res_lo}, 64'hFFFFFFFF_FFFFFFFD);
        handshake();

        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("div_ovf", {bus.res_hi, bus.res_lo}, 64'h00000000_80000000);
        handshake();

        run(OP_DIVU, 32'd100, 32'd7, lat);
        chk("divu_res", {bus.res_hi, bus.res_lo}, 64'h00000002_0000000E);
        handshake();

        run(OP_DIVU, 32'd100, 32'd0, lat);
        chk("div0_lat", 64'(lat), 64'd1);
        chk("div0_res", {bus.res_hi, bus.res_lo}, 64'h00000064_FFFFFFFF);
        handshake();

        run(OP_DIV, 32'hFFFFFFF6, 32'd0, lat);
        chk("sdiv0_res", {bus.res_hi, bus.res_lo}, 64'hFFFFFFF6_FFFFFFFF);
        handshake();

        run(OP_MUL, 32'hFFFFFFFD, 32'hFFFFFFFB, lat);
        chk("mul_negneg", {bus.res_hi, bus.res_lo}, 64'h00000000_0000000F);
        handshake();

        // consumer stalls: result and out_valid must hold, no new accept
        bus.out_ready = 1'b0;
        run(OP_MULU, 32'h00010000, 32'h00010003, lat);
        hold_lo = bus.res_lo;
        hold_hi = bus.res_hi;
        chk("hold_res", {hold_hi, hold_lo}, 64'h00000001_00030000);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_ovalid", {63'd0, bus.out_valid}, 64'd1);
            chk("hold_stable", {bus.res_hi, bus.res_lo}, {hold_hi, hold_lo});
            chk("hold_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        handshake();
        chk("idle_keep", {bus.res_hi, bus.res_lo}, {hold_hi, hold_lo});
        chk("idle_ovalid", {63'd0, bus.out_valid}, 64'd0);

        // flush in IDLE beats a simultaneous request
        @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.mdu_op = OP_MUL;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_noacc", {63'd0, bus.busy}, 64'd0);

        // flush at CALC cycle 10
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mdu_op = OP_MUL;
        bus.src1 = 32'd1234;
        bus.src2 = 32'd5678;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        chk("flush_idle", {63'd0, bus.in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 seen = seen | bus.out_valid;
        end
        chk("flush_noval", {63'd0, seen}, 64'd0);
        run(OP_MULU, 32'd3, 32'd5, lat);
        chk("post_flush", {bus.res_hi, bus.res_lo}, 64'h00000000_0000000F);
        handshake();

        // asynchronous reset mid-operation
        run(OP_MUL, 32'd7, 32'd9, lat);
        handshake();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.src1 = 32'd11;
        bus.src2 = 32'd13;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, bus.busy}, 64'd0);
        chk("arst_res", {bus.res_hi, bus.res_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_ready", {63'd0, bus.in_ready}, 64'd1);
        run(OP_MUL, 32'hFFFFFFF9, 32'd6, lat);
        chk("arst_after", {bus.res_hi, bus.res_lo}, 64'hFFFFFFFF_FFFFFFD6);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
